// File: rtl/deserializador_bc_if.sv
// Serial link bundle for the comma-framed receiver: one serial input bit in,
// the 9-bit {valid, data} word, the byte strobe and the link status out.
`timescale 1ns/1ps
interface deserializador_bc_if;
   logic       serial;
   logic [8:0] out_paralelo;
   logic       byte_stb;
   logic       active;

   modport master (output serial, input out_paralelo, input byte_stb, input active);
   modport slave  (input serial, output out_paralelo, output byte_stb, output active);
endinterface

// File: rtl/deserializador_bc.sv
// Serial-to-parallel receiver: hunts for the comma byte, confirms N_COMMA
// aligned commas, then emits one {valid, data} word per received byte.
`timescale 1ns/1ps
module deserializador_bc #(
   parameter logic [7:0]  COMMA   = 8'hBC,
   parameter int unsigned N_COMMA = 4
) (
   input logic              clk8f,
   input logic              reset,
   deserializador_bc_if.slave link
);

   typedef enum logic [1:0] {HUNT, SYNC, ACTIVE} state_t;

   localparam logic [3:0] N_COMMA_L = 4'(N_COMMA);

   state_t     state, state_nx;
   logic [7:0] shreg;
   logic [7:0] byte_next;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [3:0] comma_cnt, comma_cnt_nx;
   logic [3:0] comma_inc;
   logic [8:0] out_reg, out_nx;
   logic       stb_reg, stb_nx;
   logic       is_comma;

   assign byte_next = {shreg[6:0], link.serial};
   assign is_comma  = (byte_next == COMMA);
   assign comma_inc = comma_cnt + 4'd1;

   always_ff @(posedge clk8f or posedge reset) begin
      if (reset) begin
         state     <= HUNT;
         shreg     <= 8'h00;
         bit_cnt   <= 3'd0;
         comma_cnt <= 4'd0;
         out_reg   <= 9'h000;
         stb_reg   <= 1'b0;
      end else begin
         state     <= state_nx;
         shreg     <= byte_next;
         bit_cnt   <= bit_cnt_nx;
         comma_cnt <= comma_cnt_nx;
         out_reg   <= out_nx;
         stb_reg   <= stb_nx;
      end
   end

   // The byte boundary is the edge where bit_cnt is 7, since the match edge
   // itself resets bit_cnt to 0 and eight more bits complete the next byte.
   always_comb begin
      state_nx     = state;
      bit_cnt_nx   = bit_cnt + 3'd1;
      comma_cnt_nx = comma_cnt;
      out_nx       = out_reg;
      stb_nx       = 1'b0;
      case (state)
         HUNT: begin
            bit_cnt_nx = 3'd0;
            if (is_comma) begin
               comma_cnt_nx = 4'd1;
               state_nx     = (N_COMMA_L == 4'd1) ? ACTIVE : SYNC;
            end
         end
         SYNC: begin
            if (bit_cnt == 3'd7) begin
               if (is_comma) begin
                  comma_cnt_nx = comma_inc;
                  if (comma_inc >= N_COMMA_L) begin
                     state_nx = ACTIVE;
                  end
               end else begin
                  comma_cnt_nx = 4'd0;
                  state_nx     = HUNT;
               end
            end
         end
         ACTIVE: begin
            if (bit_cnt == 3'd7) begin
               stb_nx = 1'b1;
               out_nx = is_comma ? {1'b0, out_reg[7:0]} : {1'b1, byte_next};
            end
         end
         default: begin
            state_nx = HUNT;
         end
      endcase
   end

   assign link.out_paralelo = out_reg;
   assign link.byte_stb     = stb_reg;
   assign link.active       = (state == ACTIVE);

endmodule

// File: tb/tb_deserializador_bc.sv
// Bench for deserializador_bc: two instances (BC/4 and F0/1) fed the same bit
// stream, compared each cycle against a bit-history reference model.
`timescale 1ns/1ps
module tb_deserializador_bc;

   logic clk8f;
   logic reset;

   deserializador_bc_if bus0 ();
   deserializador_bc_if bus1 ();

   deserializador_bc #(.COMMA(8'hBC), .N_COMMA(4)) dut0 (
      .clk8f (clk8f),
      .reset (reset),
      .link  (bus0)
   );

   deserializador_bc #(.COMMA(8'hF0), .N_COMMA(1)) dut1 (
      .clk8f (clk8f),
      .reset (reset),
      .link  (bus1)
   );

   initial clk8f = 1'b0;
   always #5 clk8f = ~clk8f;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: bits since reset plus, per instance, the edge index of
   // the last alignment point (-1 while hunting) and the confirmed comma count.
   bit         hist[$];
   int         edge_n;
   logic [7:0] comma_of [2] = '{8'hBC, 8'hF0};
   int         ncomma_of[2] = '{4, 1};
   int         anchor [2];
   int         commas [2];
   bit         m_act  [2];
   bit         m_stb  [2];
   logic [8:0] m_word [2];

   function automatic logic [7:0] last_byte();
      logic [7:0] w = 8'h00;
      for (int k = 0; k < 8; k++) begin
         int idx = hist.size() - 8 + k;
         w = {w[6:0], (idx >= 0) ? logic'(hist[idx]) : 1'b0};
      end
      return w;
   endfunction

   task automatic model_reset();
      hist.delete();
      edge_n = 0;
      for (int i = 0; i < 2; i++) begin
         anchor[i] = -1;
         commas[i] = 0;
         m_act[i]  = 1'b0;
         m_stb[i]  = 1'b0;
         m_word[i] = 9'h000;
      end
   endtask

   task automatic model_step(input bit b);
      logic [7:0] w;
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
      edge_n++;
      w = last_byte();
      for (int i = 0; i < 2; i++) begin
         m_stb[i] = 1'b0;
         if (anchor[i] < 0) begin
            if (w == comma_of[i]) begin
               anchor[i] = edge_n;
               commas[i] = 1;
               if (ncomma_of[i] == 1) m_act[i] = 1'b1;
            end
         end else if ((edge_n - anchor[i]) % 8 == 0) begin
            if (m_act[i]) begin
               m_stb[i]  = 1'b1;
               m_word[i] = (w != comma_of[i]) ? {1'b1, w} : {1'b0, m_word[i][7:0]};
            end else if (w == comma_of[i]) begin
               commas[i]++;
               if (commas[i] == ncomma_of[i]) m_act[i] = 1'b1;
            end else begin
               anchor[i] = -1;
               commas[i] = 0;
            end
         end
      end
   endtask

   task automatic check_value(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic checkOutput();
      check_value("out0",    bus0.out_paralelo,        m_word[0]);
      check_value("stb0",    {8'h00, bus0.byte_stb},   {8'h00, m_stb[0]});
      check_value("active0", {8'h00, bus0.active},     {8'h00, m_act[0]});
      check_value("out1",    bus1.out_paralelo,        m_word[1]);
      check_value("stb1",    {8'h00, bus1.byte_stb},   {8'h00, m_stb[1]});
      check_value("active1", {8'h00, bus1.active},     {8'h00, m_act[1]});
   endtask

   // Drive one bit, let the edge sample it, then compare just after the edge.
   task automatic applyStimulus(input bit b);
      bus0.serial = b;
      bus1.serial = b;
      @(posedge clk8f);
      model_step(b);
      #1;
      checkOutput();
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int k = 7; k >= 0; k--) applyStimulus(v[k]);
   endtask

   // Reset is raised between edges so the outputs must clear with no clock.
   task automatic apply_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check_value("rst_out0",    bus0.out_paralelo,    9'h000);
      check_value("rst_active0", {8'h00, bus0.active}, 9'h000);
      check_value("rst_stb0",    {8'h00, bus0.byte_stb}, 9'h000);
      checkOutput();
      @(posedge clk8f);
      #1;
      reset = 1'b0;
   endtask

   logic [7:0] rnd;

   initial begin
      reset       = 1'b1;
      bus0.serial = 1'b0;
      bus1.serial = 1'b0;
      model_reset();
      repeat (2) @(posedge clk8f);
      #1;
      checkOutput();
      reset = 1'b0;

      $display("[TB] clean sync");
      repeat (3) send_byte(8'hBC);
      check_value("clean_pre_active", {8'h00, bus0.active}, 9'h000);
      send_byte(8'hBC);
      check_value("clean_active", {8'h00, bus0.active}, 9'h001);
      check_value("clean_out", bus0.out_paralelo, 9'h000);
      send_byte(8'hA5);
      check_value("clean_a5", bus0.out_paralelo, 9'h1A5);
      check_value("clean_a5_stb", {8'h00, bus0.byte_stb}, 9'h001);
      applyStimulus(1'b0);
      check_value("clean_stb_drop", {8'h00, bus0.byte_stb}, 9'h000);
      check_value("clean_hold", bus0.out_paralelo, 9'h1A5);
      repeat (7) applyStimulus(1'($urandom_range(0, 1)));

      $display("[TB] idle in active");
      send_byte(8'h7E);
      check_value("idle_7e", bus0.out_paralelo, 9'h17E);
      send_byte(8'hBC);
      check_value("idle_bc1", bus0.out_paralelo, 9'h07E);
      check_value("idle_bc1_stb", {8'h00, bus0.byte_stb}, 9'h001);
      send_byte(8'hBC);
      check_value("idle_bc2", bus0.out_paralelo, 9'h07E);
      send_byte(8'h01);
      check_value("idle_01", bus0.out_paralelo, 9'h101);

      $display("[TB] reset mid-operation");
      repeat (3) applyStimulus(1'($urandom_range(0, 1)));
      apply_reset();
      for (int i = 0; i < 6; i++) send_byte(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
      check_value("no_comma_inactive", {8'h00, bus0.active}, 9'h000);

      $display("[TB] misaligned start");
      apply_reset();
      repeat (3) applyStimulus(1'($urandom_range(0, 1)));
      repeat (3) send_byte(8'hBC);
      check_value("mis_pre_active", {8'h00, bus0.active}, 9'h000);
      send_byte(8'hBC);
      check_value("mis_active", {8'h00, bus0.active}, 9'h001);
      send_byte(8'h3C);
      check_value("mis_3c", bus0.out_paralelo, 9'h13C);

      $display("[TB] broken sync");
      apply_reset();
      repeat (3) send_byte(8'hBC);
      send_byte(8'h55);
      check_value("brk_after_55", {8'h00, bus0.active}, 9'h000);
      repeat (3) send_byte(8'hBC);
      check_value("brk_pre_active", {8'h00, bus0.active}, 9'h000);
      send_byte(8'hBC);
      check_value("brk_active", {8'h00, bus0.active}, 9'h001);
      send_byte(8'h81);
      check_value("brk_81", bus0.out_paralelo, 9'h181);

      $display("[TB] random traffic");
      for (int i = 0; i < 24; i++) begin
         rnd = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) rnd = 8'hBC;
         send_byte(rnd);
      end

      $display("[TB] parameters F0 / 1");
      apply_reset();
      send_byte(8'hF0);
      check_value("par_active", {8'h00, bus1.active}, 9'h001);
      check_value("par_out", bus1.out_paralelo, 9'h000);
      send_byte(8'h0F);
      check_value("par_0f", bus1.out_paralelo, 9'h10F);
      check_value("par_0f_stb", {8'h00, bus1.byte_stb}, 9'h001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
